spram_readout: RTL and testbench

SPRAM_READOUT -- requirements
Module: spram_readout

---
 rtl/spram_readout.sv | 141 ++++++++++++++
 tb/tb_spram_readout.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_readout.sv
// Streams 16-bit SPRAM words MSB-first to a ready/valid serial sink.
// Define SPRAM_READOUT_LOOP_EN to repeat the frame until abort or reset.
module spram_readout (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] num_words,
    input  logic        abort,
    output logic [13:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StLoad,
        StShift,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [13:0] count_q, count_d;
    logic [13:0] idx_q, idx_d;
    logic [13:0] addr_q, addr_d;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        abort_q, abort_d;
    logic        done_q, done_d;

    logic        handshake;
    logic        last_bit;
    logic        stop_req;
    logic [13:0] idx_inc;

    assign handshake = (state_q == StShift) && bit_ready;
    assign last_bit  = handshake && (bit_cnt_q == 5'd1);
    assign idx_inc   = idx_q + 14'd1;
    // An abort arriving on the final handshake still ends the frame at this boundary.
    assign stop_req  = abort_q | abort;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        abort_d   = abort_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && (num_words != 14'd0)) begin
                    count_d = num_words;
                    idx_d   = 14'd0;
                    addr_d  = 14'd0;
                    abort_d = 1'b0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = StLoad;
            end
            StLoad: begin
                shreg_d   = rd_data;
                bit_cnt_d = 5'd16;
                state_d   = StShift;
            end
            StShift: begin
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (handshake) begin
                    shreg_d   = {shreg_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 5'd1;
                end
                if (last_bit) begin
                    idx_d = idx_inc;
                    if (stop_req) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (idx_inc == count_q) begin
                        done_d = 1'b1;
`ifdef SPRAM_READOUT_LOOP_EN
                        // Wrap straight into the next pass; done pulses during its ADDR cycle.
                        idx_d   = 14'd0;
                        addr_d  = 14'd0;
                        state_d = StAddr;
`else
                        state_d = StDone;
`endif
                    end else begin
                        addr_d  = idx_inc;
                        state_d = StAddr;
                    end
                end
            end
            StDone: begin
                abort_d = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 14'd0;
            idx_q     <= 14'd0;
            addr_q    <= 14'd0;
            shreg_q   <= 16'd0;
            bit_cnt_q <= 5'd0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
        end
    end

    assign rd_addr   = addr_q;
    assign bit_out   = shreg_q[15];
    assign bit_valid = (state_q == StShift);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_spram_readout.sv
// Self-checking bench for spram_readout: SPRAM model, stream monitor and word-level reference model.
`timescale 1ns/1ps
module tb_spram_readout;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] num_words = 14'd0;
    logic        abort = 1'b0;
    logic [13:0] rd_addr;
    logic [15:0] rd_data;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready = 1'b0;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:63];

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor state
    bit          mon_bits[$];
    logic [13:0] mon_addrs[$];
    int          mon_gaps[$];
    int          done_cnt = 0;
    int          hold_viol = 0;
    int          gap = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_bit = 1'b0;

    // Reference model output
    bit          exp_bits[$];
    logic [13:0] exp_addrs[$];

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr[5:0]];

    spram_readout dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done)
    );

    always @(negedge clk) begin
        if (bit_valid && bit_ready) mon_bits.push_back(bit_out);
        if (bit_valid && !prev_valid) mon_addrs.push_back(rd_addr);
        if (done) done_cnt++;
        if (bit_valid) begin
            if (!prev_valid) mon_gaps.push_back(gap);
            gap = 0;
        end else if (busy) begin
            gap++;
        end else begin
            gap = 0;
        end
        if (prev_valid && !prev_ready && (bit_valid !== 1'b1 || bit_out !== prev_bit)) hold_viol++;
        prev_valid = bit_valid;
        prev_ready = bit_ready;
        prev_bit   = bit_out;
    end

    task automatic mon_clear();
        mon_bits.delete();
        mon_addrs.delete();
        mon_gaps.delete();
        exp_bits.delete();
        exp_addrs.delete();
        done_cnt  = 0;
        hold_viol = 0;
    endtask

    task automatic model_word(input int w);
        exp_addrs.push_back(w[13:0]);
        for (int b = 15; b >= 0; b--) exp_bits.push_back(mem[w][b]);
    endtask

    function automatic int bit_diffs();
        int d = 0;
        if (mon_bits.size() != exp_bits.size()) d++;
        for (int i = 0; i < mon_bits.size() && i < exp_bits.size(); i++)
            if (mon_bits[i] !== exp_bits[i]) d++;
        return d;
    endfunction

    function automatic int addr_diffs();
        int d = 0;
        if (mon_addrs.size() != exp_addrs.size()) d++;
        for (int i = 0; i < mon_addrs.size() && i < exp_addrs.size(); i++)
            if (mon_addrs[i] !== exp_addrs[i]) d++;
        return d;
    endfunction

    function automatic int bad_gaps();
        int d = 0;
        foreach (mon_gaps[i]) if (mon_gaps[i] != 2) d++;
        return d;
    endfunction

    function automatic logic [31:0] packed_bits(input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n && i < mon_bits.size(); i++) v = {v[30:0], mon_bits[i]};
        return v;
    endfunction

    task automatic drive_ready(input int mode, inout bit tog);
        case (mode)
            0: bit_ready = 1'b1;
            1: begin bit_ready = tog; tog = ~tog; end
            default: bit_ready = ($urandom % 4) != 0;
        endcase
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        num_words = n[13:0];
        @(posedge clk); #1;
        start = 1'b0;
        num_words = 14'($urandom);
    endtask

    // Runs until a done pulse has been seen and the DUT is idle again.
    task automatic wait_idle(input int mode, input bit stray, input int budget, output bit to);
        int cyc = 0;
        bit tog = 1'b1;
        bit injected = 1'b0;
        to = 1'b0;
        while (!(done_cnt > 0 && !busy)) begin
            drive_ready(mode, tog);
            if (stray && !injected && bit_valid) begin
                start = 1'b1;
                num_words = 14'($urandom_range(1, 40));
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > budget) begin
                to = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; num_words = 14'd5; abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run += 5;
        if (rd_addr !== 14'd0) begin tests_failed++; $display("FAIL reset_rd_addr got %0h want 0", rd_addr); end
        if (bit_out !== 1'b0) begin tests_failed++; $display("FAIL reset_bit_out got %b want 0", bit_out); end
        if (bit_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_bit_valid got %b want 0", bit_valid); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_priority busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        bit to;
        mon_clear();
        mem[0] = 16'hA5C3;
        mem[1] = 16'h0F0F;
        model_word(0);
        model_word(1);
        pulse_start(2);
        wait_idle(0, 1'b0, 200, to);
        tests_run += 6;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout got %b want 0", to); end
        if (packed_bits(32) !== 32'hA5C3_0F0F || mon_bits.size() != 32) begin
            tests_failed++;
            $display("FAIL basic_stream got %h (%0d bits) want a5c30f0f (32 bits)", packed_bits(32),
                     mon_bits.size());
        end
        if (addr_diffs() != 0) begin tests_failed++; $display("FAIL basic_addrs got %0d diffs want 0", addr_diffs()); end
        if (done_cnt != 1) begin tests_failed++; $display("FAIL basic_done got %0d pulses want 1", done_cnt); end
        if (bad_gaps() != 0) begin tests_failed++; $display("FAIL basic_gap got %0d bad gaps want 0", bad_gaps()); end
        if (mon_gaps.size() != 2) begin tests_failed++; $display("FAIL basic_words got %0d want 2", mon_gaps.size()); end
    endtask

    task automatic test_backpressure();
        bit to;
        mon_clear();
        mem[0] = 16'h8001;
        model_word(0);
        pulse_start(1);
        wait_idle(1, 1'b0, 200, to);
        tests_run += 4;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout got %b want 0", to); end
        if (packed_bits(16) !== 32'h0000_8001 || mon_bits.size() != 16) begin
            tests_failed++;
            $display("FAIL bp_stream got %h (%0d bits) want 8001 (16 bits)", packed_bits(16), mon_bits.size());
        end
        if (hold_viol != 0) begin tests_failed++; $display("FAIL bp_hold got %0d violations want 0", hold_viol); end
        if (done_cnt != 1) begin tests_failed++; $display("FAIL bp_done got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_zero();
        logic seen = 1'b0;
        mon_clear();
        pulse_start(0);
        repeat (20) begin
            @(posedge clk); #1;
            seen = seen | busy | bit_valid | done | (|rd_addr);
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL zero_start activity got %b want 0", seen); end
    endtask

    task automatic test_idle_abort();
        bit to;
        mon_clear();
        mem[0] = 16'($urandom);
        model_word(0);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        pulse_start(1);
        wait_idle(0, 1'b0, 200, to);
        tests_run += 2;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL idle_abort_timeout got %b want 0", to); end
        if (bit_diffs() != 0) begin tests_failed++; $display("FAIL idle_abort_stream got %0d diffs want 0", bit_diffs()); end
    endtask

    task automatic test_abort();
        int cyc = 0;
        bit fired = 1'b0;
        bit saw2 = 1'b0;
        mon_clear();
        for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
        model_word(0);
        model_word(1);
        pulse_start(4);
        bit_ready = 1'b1;
        while (!(done_cnt > 0 && !busy) && cyc < 400) begin
            if (!fired && bit_valid && mon_bits.size() == 21) begin
                abort = 1'b1;
                fired = 1'b1;
            end else begin
                abort = 1'b0;
            end
            @(posedge clk); #1;
            if (rd_addr == 14'd2) saw2 = 1'b1;
            cyc++;
        end
        abort = 1'b0;
        tests_run += 5;
        if (cyc >= 400) begin tests_failed++; $display("FAIL abort_timeout got %0d cycles want <400", cyc); end
        if (bit_diffs() != 0) begin tests_failed++; $display("FAIL abort_stream got %0d diffs want 0", bit_diffs()); end
        if (addr_diffs() != 0) begin tests_failed++; $display("FAIL abort_addrs got %0d diffs want 0", addr_diffs()); end
        if (saw2 !== 1'b0) begin tests_failed++; $display("FAIL abort_word2 addressed got %b want 0", saw2); end
        if (done_cnt != 1) begin tests_failed++; $display("FAIL abort_done got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        bit to;
        mon_clear();
        for (int i = 0; i < 3; i++) mem[i] = 16'($urandom);
        pulse_start(3);
        bit_ready = 1'b1;
        while (!(bit_valid && mon_bits.size() == 9) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run += 4;
        if (cyc >= 100) begin tests_failed++; $display("FAIL rstmid_reach got %0d cycles want <100", cyc); end
        if (bit_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid got %b want 0", bit_valid); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (rd_addr !== 14'd0) begin tests_failed++; $display("FAIL rstmid_addr got %0h want 0", rd_addr); end
        reset = 1'b0;
        mon_clear();
        model_word(0);
        pulse_start(1);
        wait_idle(0, 1'b0, 200, to);
        tests_run += 3;
        if (to !== 1'b0) begin tests_failed++; $display("FAIL rstmid_timeout got %b want 0", to); end
        if (addr_diffs() != 0) begin tests_failed++; $display("FAIL rstmid_restart_addr got %0d diffs want 0", addr_diffs()); end
        if (bit_diffs() != 0) begin tests_failed++; $display("FAIL rstmid_stream got %0d diffs want 0", bit_diffs()); end
    endtask

    task automatic test_random();
        bit to;
        int n;
        for (int it = 0; it < 8; it++) begin
            mon_clear();
            for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
            n = $urandom_range(1, 8);
            for (int w = 0; w < n; w++) model_word(w);
            pulse_start(n);
            wait_idle(2, it[0], 3000, to);
            tests_run += 6;
            if (to !== 1'b0) begin tests_failed++; $display("FAIL rand%0d_timeout got %b want 0", it, to); end
            if (bit_diffs() != 0) begin tests_failed++; $display("FAIL rand%0d_stream got %0d diffs want 0", it, bit_diffs()); end
            if (addr_diffs() != 0) begin tests_failed++; $display("FAIL rand%0d_addrs got %0d diffs want 0", it, addr_diffs()); end
            if (done_cnt != 1) begin tests_failed++; $display("FAIL rand%0d_done got %0d want 1", it, done_cnt); end
            if (bad_gaps() != 0) begin tests_failed++; $display("FAIL rand%0d_gap got %0d bad want 0", it, bad_gaps()); end
            if (hold_viol != 0) begin tests_failed++; $display("FAIL rand%0d_hold got %0d want 0", it, hold_viol); end
        end
    endtask

`ifdef SPRAM_READOUT_LOOP_EN
    task automatic test_loop();
        int cyc = 0;
        bit fired = 1'b0;
        bit dropped = 1'b0;
        mon_clear();
        mem[0] = 16'($urandom);
        mem[1] = 16'($urandom);
        for (int k = 0; k < 5; k++) model_word(k % 2);
        pulse_start(2);
        bit_ready = 1'b1;
        while (!(fired && !busy) && cyc < 600) begin
            if (!fired && done_cnt >= 2 && bit_valid) begin
                abort = 1'b1;
                fired = 1'b1;
            end else begin
                abort = 1'b0;
            end
            @(posedge clk); #1;
            if (!busy && done_cnt < 3) dropped = 1'b1;
            cyc++;
        end
        abort = 1'b0;
        tests_run += 6;
        if (cyc >= 600) begin tests_failed++; $display("FAIL loop_timeout got %0d want <600", cyc); end
        if (addr_diffs() != 0) begin tests_failed++; $display("FAIL loop_addrs got %0d diffs want 0", addr_diffs()); end
        if (bit_diffs() != 0) begin tests_failed++; $display("FAIL loop_stream got %0d diffs want 0", bit_diffs()); end
        if (done_cnt != 3) begin tests_failed++; $display("FAIL loop_done got %0d want 3", done_cnt); end
        if (bad_gaps() != 0) begin tests_failed++; $display("FAIL loop_gap got %0d bad want 0", bad_gaps()); end
        if (dropped !== 1'b0) begin tests_failed++; $display("FAIL loop_busy dropped got %b want 0", dropped); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'd0;
        test_reset();
        test_zero();
`ifdef SPRAM_READOUT_LOOP_EN
        test_loop();
`else
        test_basic();
        test_backpressure();
        test_idle_abort();
        test_abort();
        test_reset_mid();
        test_random();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
